prefix_addsub_pipe: RTL and testbench

- Pipelined parallel-prefix adder/subtractor.
- Consumes operand pairs, forms bitwise p/g, resolves group P/G through log2(WIDTH) prefix levels, and emits sum, carry-out and signed overflow.
- Sits downstream of operand sources and upstream of result sinks. Valid/ready handshakes on both sides.

---
 rtl/prefix_addsub_pipe.sv | 134 +++++++++++++
 tb/tb_prefix_addsub_pipe.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/prefix_addsub_pipe.sv
// Two-stage Kogge-Stone adder/subtractor with valid/ready handshakes.
// Define PREFIX_ADDSUB_SAT_EN to saturate the sum on signed overflow.
module prefix_addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [CNT_W-1:0] op_cnt
);

    // Returns {c[WIDTH..1], c0}; bit 0 of the group generate absorbs c0.
    function automatic logic [WIDTH:0] ks_carry(
        input logic [WIDTH-1:0] p,
        input logic [WIDTH-1:0] g,
        input logic             c0
    );
        logic [WIDTH-1:0] gg, pp, gn, pn;
        gg    = g;
        pp    = p;
        gg[0] = g[0] | (p[0] & c0);
        for (int d = 1; d < WIDTH; d = d * 2) begin
            gn = gg;
            pn = pp;
            for (int i = d; i < WIDTH; i++) begin
                gn[i] = gg[i] | (pp[i] & gg[i-d]);
                pn[i] = pp[i] & pp[i-d];
            end
            gg = gn;
            pp = pn;
        end
        return {gg, c0};
    endfunction

    logic             w_adv;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_g;
    logic             w_c0;
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_sum_raw;
    logic [WIDTH-1:0] w_sum_nxt;
    logic             w_ovf;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_g;
    logic             r_c0;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    assign w_b_eff = b ^ {WIDTH{sub}};
    assign w_c0    = cin ^ sub;
    assign w_p     = a ^ w_b_eff;
    assign w_g     = a & w_b_eff;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_p        <= '0;
            r_g        <= '0;
            r_c0       <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            r_p        <= w_p;
            r_g        <= w_g;
            r_c0       <= w_c0;
        end
    end

    assign w_c       = ks_carry(r_p, r_g, r_c0);
    assign w_sum_raw = r_p ^ w_c[WIDTH-1:0];
    assign w_ovf     = w_c[WIDTH] ^ w_c[WIDTH-1];

`ifdef PREFIX_ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Sign of A is needed to pick the saturation rail.
    logic r_a_msb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_msb <= 1'b0;
        end else if (w_adv) begin
            r_a_msb <= a[WIDTH-1];
        end
    end

    always_comb begin
        w_sum_nxt = w_sum_raw;
        if (w_ovf) begin
            w_sum_nxt = r_a_msb ? MIN_NEG : MAX_POS;
        end
    end
`else
    assign w_sum_nxt = w_sum_raw;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (w_adv) begin
            out_valid <= r_s1_valid;
            sum       <= w_sum_nxt;
            cout      <= w_c[WIDTH];
            ovf       <= w_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_cnt <= '0;
        end else if (out_valid && out_ready) begin
            op_cnt <= op_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_prefix_addsub_pipe.sv
// Bench for prefix_addsub_pipe: arithmetic reference model, scoreboard
// and directed vectors (WIDTH=16, CNT_W=4 so the counter wraps quickly).
module tb_prefix_addsub_pipe;

    localparam int W  = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          sub;
    logic          cin;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic [CW-1:0] op_cnt;

    prefix_addsub_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .op_cnt(op_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } exp_t;

    int errors = 0;
    int checks = 0;
    exp_t          q[$];
    logic [W-1:0]  log_q[$];
    logic [CW-1:0] m_cnt = '0;
    bit            saw_stall = 0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Plain integer arithmetic; overflow from operand/result signs.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic ms, input logic mc);
        exp_t         e;
        logic [W-1:0] be;
        logic [W:0]   x;
        be   = ms ? ~mb : mb;
        x    = {1'b0, ma} + {1'b0, be} + (W+1)'(mc ^ ms);
        e.s  = x[W-1:0];
        e.co = x[W];
        e.ov = (ma[W-1] == be[W-1]) && (x[W-1] != ma[W-1]);
`ifdef PREFIX_ADDSUB_SAT_EN
        if (e.ov) e.s = ma[W-1] ? 16'h8000 : 16'h7FFF;
`endif
        return e;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            log_q.delete();
            m_cnt = '0;
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() > 0) void'(q.pop_front());
                log_q.push_back(sum);
                m_cnt = m_cnt + 1'b1;
            end
            if (in_valid && in_ready) q.push_back(model(a, b, sub, cin));
        end
    end

    always @(posedge clk) begin
        #2;
        check("op_cnt", 32'(op_cnt), 32'(m_cnt));
        check("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
        if (out_valid && !out_ready && !in_ready) saw_stall = 1;
        if (out_valid) begin
            if (q.size() == 0) begin
                check("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
                check("sum", 32'(sum), 32'(q[0].s));
                check("cout", 32'(cout), 32'(q[0].co));
                check("ovf", 32'(ovf), 32'(q[0].ov));
            end
        end
    end

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic ts, input logic tc);
        int   n;
        logic acc;
        n   = 0;
        acc = 0;
        @(negedge clk);
        a = ta; b = tb; sub = ts; cin = tc; in_valid = 1'b1;
        while (!acc && n < 100) begin
            #1 acc = in_ready;
            @(posedge clk);
            n++;
            if (!acc) @(negedge clk);
        end
        if (!acc) check("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        #2;
        check("drain", 32'(q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One op, then check the registered result exactly 2 edges after accept.
    task automatic direct(input string name, input logic [W-1:0] ta,
                          input logic [W-1:0] tb, input logic ts, input logic tc,
                          input logic [W-1:0] es, input logic eco, input logic eov);
        send(ta, tb, ts, tc);
        idle();
        @(posedge clk);
        #2;
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_sum"}, 32'(sum), 32'(es));
        check({name, "_cout"}, 32'(cout), 32'(eco));
        check({name, "_ovf"}, 32'(ovf), 32'(eov));
        drain();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        a = 16'h1234; b = 16'h1111; sub = 1'b0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_op_cnt", 32'(op_cnt), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd1);

`ifdef PREFIX_ADDSUB_SAT_EN
        direct("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        direct("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h8000, 1'b1, 1'b1);
`else
        direct("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        direct("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
`endif
        direct("sub_borrow", 16'h0003, 16'h0005, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        direct("sub_bin", 16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);
        direct("carry_chain", 16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

        do_reset();
        saw_stall = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(W'(i), W'(i), 1'b0, 1'b0);
                idle();
            end
            begin
                repeat (3) @(negedge clk);
                out_ready = 1'b0;
                repeat (4) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_stall_seen", 32'(saw_stall), 32'd1);
        check("bp_count", 32'(log_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < log_q.size(); i++)
            check("bp_order", 32'(log_q[i]), 32'(2 * i));
        check("bp_op_cnt", 32'(op_cnt), 32'd8);

        do_reset();
        for (int i = 0; i < 16; i++)
            send(W'(i * 3), W'(i), i[0], 1'b0);
        idle();
        drain();
        check("wrap_delivered", 32'(log_q.size()), 32'd16);
        check("wrap_op_cnt", 32'(op_cnt), 32'd0);

        @(negedge clk);
        out_ready = 1'b0;
        send(16'h0101, 16'h0202, 1'b0, 1'b0);
        send(16'h0303, 16'h0404, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #2;
            check("flush_out_valid", 32'(out_valid), 32'd0);
        end
        check("flush_op_cnt", 32'(op_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
